// File: rtl/map_row_prefetch_pkg.sv
// ============================================================================
//  map_row_prefetch_pkg
//  Shared state encoding and map geometry for the map overlay, the tracer and
//  the row prefetcher.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package map_row_prefetch_pkg;

    localparam int MAP_WIDTH_BITS_DEF  = 4;
    localparam int MAP_HEIGHT_BITS_DEF = 4;
    localparam int MAP_SCALE_DEF       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of video lines covered by the overlay.
    function automatic int ov_lines(input int height_bits, input int scale);
        return (1 << height_bits) << scale;
    endfunction

endpackage

`default_nettype wire

// File: rtl/map_row_prefetch_if.sv
// ============================================================================
//  map_row_prefetch_if
//  Map ROM req/gnt port plus the overlay lookup port of the row prefetcher.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface map_row_prefetch_if
    import map_row_prefetch_pkg::*;
#(
    parameter int MAP_WIDTH_BITS  = MAP_WIDTH_BITS_DEF,
    parameter int MAP_HEIGHT_BITS = MAP_HEIGHT_BITS_DEF
);
    logic                       o_map_req;
    logic                       i_map_gnt;
    logic [MAP_WIDTH_BITS-1:0]  o_map_col;
    logic [MAP_HEIGHT_BITS-1:0] o_map_row;
    logic                       i_map_val;
    logic [MAP_WIDTH_BITS-1:0]  i_ov_col;
    logic                       o_ov_val;

    modport master (
        output o_map_req, o_map_col, o_map_row, o_ov_val,
        input  i_map_gnt, i_map_val, i_ov_col
    );

    modport slave (
        input  o_map_req, o_map_col, o_map_row, o_ov_val,
        output i_map_gnt, i_map_val, i_ov_col
    );

endinterface

`default_nettype wire

// File: rtl/map_row_prefetch_buffer.sv
// ============================================================================
//  map_row_buffer
//  Double-buffered map row: back buffer is written per column, front buffer
//  is read combinationally by the overlay.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module map_row_buffer #(
    parameter int WIDTH_BITS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  i_wr_en,
    input  wire logic [WIDTH_BITS-1:0] i_wr_col,
    input  wire logic                  i_wr_val,
    input  wire logic                  i_clear,
    input  wire logic                  i_load_front,
    input  wire logic                  i_swap,
    input  wire logic [WIDTH_BITS-1:0] i_rd_col,
    output logic                       o_rd_val
);
    localparam int C_BITS = 1 << WIDTH_BITS;

    logic [C_BITS-1:0] front_q, front_d;
    logic [C_BITS-1:0] back_q,  back_d;

    always_comb begin
        front_d = front_q;
        back_d  = back_q;
        if (i_clear) begin
            back_d = '0;
        end else if (i_load_front) begin
            back_d = front_q;
        end else if (i_wr_en) begin
            back_d[i_wr_col] = i_wr_val;
        end
        if (i_swap) begin
            front_d = back_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            front_q <= '0;
            back_q  <= '0;
        end else begin
            front_q <= front_d;
            back_q  <= back_d;
        end
    end

    assign o_rd_val = front_q[i_rd_col];

endmodule

`default_nettype wire

// File: rtl/map_row_prefetch.sv
// ============================================================================
//  map_row_prefetch
//  Fetches the next line's map row from the shared ROM during hblank and
//  swaps it to the overlay at line start. Optional: MAP_PREFETCH_SKIP_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module map_row_prefetch
    import map_row_prefetch_pkg::*;
#(
    parameter int H_VIEW          = 640,
    parameter int V_TOTAL         = 525,
    parameter int MAP_WIDTH_BITS  = MAP_WIDTH_BITS_DEF,
    parameter int MAP_HEIGHT_BITS = MAP_HEIGHT_BITS_DEF,
    parameter int MAP_SCALE       = MAP_SCALE_DEF
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic [9:0]  hpos,
    input  wire logic [9:0]  vpos,
    map_row_prefetch_if.master bus,
    output logic             o_row_valid,
    output logic             o_underrun
);
    localparam logic [10:0] C_LINE_LIMIT = 11'(ov_lines(MAP_HEIGHT_BITS, MAP_SCALE) + 1);

    state_t                     state_q, state_d;
    logic                       map_req_q, map_req_d;
    logic [MAP_WIDTH_BITS-1:0]  col_q, col_d;
    logic [MAP_HEIGHT_BITS-1:0] map_row_q, map_row_d;
    logic                       row_valid_q, row_valid_d;
    logic                       underrun_q, underrun_d;

    logic [9:0]                 w_next_v;
    logic [MAP_HEIGHT_BITS-1:0] w_fetch_row;
    logic                       w_need_fetch;
    logic                       w_line_in_range;
    logic                       w_line_start;
    logic                       w_hblank_start;
    logic                       w_skip;
    logic                       w_wr_en;
    logic                       w_clear;
    logic                       w_load_front;
    logic                       w_swap;

    assign w_next_v        = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    assign w_fetch_row     = w_next_v[MAP_SCALE+MAP_HEIGHT_BITS-1:MAP_SCALE];
    assign w_need_fetch    = ({1'b0, w_next_v} < C_LINE_LIMIT);
    assign w_line_in_range = ({1'b0, vpos} < C_LINE_LIMIT);
    assign w_line_start    = (hpos == 10'd0);
    assign w_hblank_start  = (hpos == 10'(H_VIEW));

`ifdef MAP_PREFETCH_SKIP_EN
    // Row currently shown; lets consecutive lines of one map row skip the ROM.
    logic [MAP_HEIGHT_BITS-1:0] front_row_q, front_row_d;

    assign front_row_d = w_swap ? map_row_q : front_row_q;
    assign w_skip      = row_valid_q && (w_fetch_row == front_row_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            front_row_q <= '0;
        end else begin
            front_row_q <= front_row_d;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        map_req_d    = map_req_q;
        col_d        = col_q;
        map_row_d    = map_row_q;
        row_valid_d  = row_valid_q;
        underrun_d   = underrun_q;
        w_wr_en      = 1'b0;
        w_clear      = 1'b0;
        w_load_front = 1'b0;
        w_swap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_line_start && !w_line_in_range) begin
                    row_valid_d = 1'b0;
                end else if (w_hblank_start && w_need_fetch) begin
                    map_row_d = w_fetch_row;
                    col_d     = '0;
                    if (w_skip) begin
                        w_load_front = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        w_clear   = 1'b1;
                        map_req_d = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // The line deadline wins over a grant arriving on the same cycle.
                if (w_line_start) begin
                    map_req_d   = 1'b0;
                    col_d       = '0;
                    row_valid_d = 1'b0;
                    underrun_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else if (map_req_q && bus.i_map_gnt) begin
                    w_wr_en = 1'b1;
                    col_d   = col_q + 1'b1;
                    if (col_q == '1) begin
                        map_req_d = 1'b0;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_line_start) begin
                    w_swap      = 1'b1;
                    row_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                map_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            map_req_q   <= 1'b0;
            col_q       <= '0;
            map_row_q   <= '0;
            row_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            map_req_q   <= map_req_d;
            col_q       <= col_d;
            map_row_q   <= map_row_d;
            row_valid_q <= row_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    map_row_buffer #(
        .WIDTH_BITS (MAP_WIDTH_BITS)
    ) u_row_buffer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr_en      (w_wr_en),
        .i_wr_col     (col_q),
        .i_wr_val     (bus.i_map_val),
        .i_clear      (w_clear),
        .i_load_front (w_load_front),
        .i_swap       (w_swap),
        .i_rd_col     (bus.i_ov_col),
        .o_rd_val     (bus.o_ov_val)
    );

    assign bus.o_map_req = map_req_q;
    assign bus.o_map_col = col_q;
    assign bus.o_map_row = map_row_q;
    assign o_row_valid   = row_valid_q;
    assign o_underrun    = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_map_row_prefetch.sv
// ============================================================================
//  tb_map_row_prefetch
//  Directed line-by-line bench with a ROM-address scoreboard and a row model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_map_row_prefetch;

    localparam int H_VIEW   = 640;
    localparam int HB_STEPS = 56;
    localparam int OV_LINES = 128;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       o_row_valid;
    logic       o_underrun;

    map_row_prefetch_if #(.MAP_WIDTH_BITS(4), .MAP_HEIGHT_BITS(4)) bus ();

    map_row_prefetch #(
        .H_VIEW          (640),
        .V_TOTAL         (525),
        .MAP_WIDTH_BITS  (4),
        .MAP_HEIGHT_BITS (4),
        .MAP_SCALE       (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hpos        (hpos),
        .vpos        (vpos),
        .bus         (bus),
        .o_row_valid (o_row_valid),
        .o_underrun  (o_underrun)
    );

    always #20 clk = ~clk;

    logic [15:0] rom_mem [16];
    assign bus.i_map_val = rom_mem[bus.o_map_row][bus.o_map_col];

    int          n_checks = 0;
    int          n_errors = 0;
    int          req_cycles;
    logic [7:0]  exp_q [$];

    // Row model
    logic [15:0] exp_front = '0;
    logic        exp_valid = 1'b0;
    logic        exp_under = 1'b0;
    int          front_row = 0;
    int          pend = 0;          // 0 none, 1 fetch expected to miss, 2 row ready
    logic [15:0] pend_data = '0;
    int          pend_row = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input logic g);
        logic [7:0] e;
        hpos          = 10'(h);
        bus.i_map_gnt = g;
        @(negedge clk);
        if (bus.o_map_req) req_cycles++;
        if (bus.o_map_req && bus.i_map_gnt) begin
            if (exp_q.size() == 0) begin
                check("req_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rom_addr", {24'd0, bus.o_map_row, bus.o_map_col}, {24'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_ov(input string tag);
        logic [15:0] obs;
        obs = '0;
        for (int c = 0; c < 16; c++) begin
            bus.i_ov_col = 4'(c);
            #1;
            obs[c] = bus.o_ov_val;
        end
        check(tag, {16'd0, obs}, {16'd0, exp_front});
    endtask

    // gmode: 0 grant always, 1 grant one cycle in three, 2 grant never
    task automatic run_line(input int v, input int gmode);
        int   nv;
        int   row;
        bit   need;
        bit   skip;
        logic g;
        vpos = 10'(v);
        step(0, 1'b0);
        if (pend == 2) begin
            exp_front = pend_data;
            exp_valid = 1'b1;
            front_row = pend_row;
        end else if (pend == 1) begin
            exp_valid = 1'b0;
            exp_under = 1'b1;
        end else if (v > OV_LINES) begin
            exp_valid = 1'b0;
        end
        pend = 0;
        check("row_valid", {31'd0, o_row_valid}, {31'd0, exp_valid});
        check("underrun", {31'd0, o_underrun}, {31'd0, exp_under});
        check("req_idle_at_line_start", {31'd0, bus.o_map_req}, 32'd0);
        check_ov("ov_val");
        step(1, 1'b0);

        nv   = (v == 524) ? 0 : v + 1;
        need = (nv <= OV_LINES);
        row  = (nv >> 3) & 15;
`ifdef MAP_PREFETCH_SKIP_EN
        skip = need && exp_valid && (row == front_row);
`else
        skip = 1'b0;
`endif
        if (need) begin
            pend_row = row;
            if (skip) begin
                pend      = 2;
                pend_data = exp_front;
            end else if (gmode != 2) begin
                for (int c = 0; c < 16; c++) exp_q.push_back({4'(row), 4'(c)});
                pend      = 2;
                pend_data = rom_mem[row];
            end else begin
                pend = 1;
            end
        end

        req_cycles = 0;
        for (int h = H_VIEW - 2; h <= H_VIEW + HB_STEPS; h++) begin
            g = (gmode == 0) ? 1'b1 : (gmode == 1) ? ((h % 3) == 0) : 1'b0;
            step(h, g);
        end

        if (!need || skip) begin
            check("no_req", 32'(req_cycles), 32'd0);
        end else if (gmode == 0) begin
            check("req_cycles_full_rate", 32'(req_cycles), 32'd16);
            check("fetch_complete", 32'(exp_q.size()), 32'd0);
        end else if (gmode == 1) begin
            check("req_within_48", {31'd0, req_cycles <= 48}, 32'd1);
            check("fetch_complete", 32'(exp_q.size()), 32'd0);
        end else begin
            check("req_held_no_gnt", {31'd0, bus.o_map_req}, 32'd1);
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int r = 0; r < 16; r++) rom_mem[r] = 16'($urandom);
        rom_mem[0] = 16'h3C5A;
        rom_mem[1] = 16'hA5C3;
        rom_mem[2] = 16'h0FF1;
        rom_mem[3] = 16'h96E7;
        bus.i_map_gnt = 1'b0;
        bus.i_ov_col  = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset_row_valid", {31'd0, o_row_valid}, 32'd0);
        check("reset_underrun", {31'd0, o_underrun}, 32'd0);
        check("reset_req", {31'd0, bus.o_map_req}, 32'd0);
        check("reset_addr", {24'd0, bus.o_map_row, bus.o_map_col}, 32'd0);
        check_ov("reset_ov_val");

        run_line(7, 0);     // full-rate fetch of row 1
        run_line(8, 0);
        run_line(15, 1);    // stalled grant, row 2
        run_line(16, 0);
        run_line(23, 2);    // deadline miss on row 3
        run_line(24, 0);
        run_line(25, 0);
        run_line(127, 0);   // last in-range fetch
        run_line(128, 0);
        run_line(129, 0);
        run_line(130, 0);
        run_line(300, 0);
        run_line(523, 0);
        run_line(524, 0);   // frame wrap fetches row 0
        for (int v = 0; v <= 8; v++) run_line(v, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
